// File: rtl/complex_mul_pkg.sv
// Shared sizing and saturation helpers for the streaming complex multiplier.
// Each pipeline payload width follows from DATA_W. The widths are computed by
// the functions below so that the top module can declare its stage structs.
package complex_mul_pkg;

    // Exact width of one component of the complex product.
    function automatic int full_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    // Pre-add width: b_im - b_re can reach 2^DATA_W once b_im has been negated.
    function automatic int pre_w(input int data_w);
        return data_w + 2;
    endfunction

    // Width of each of the three partial products (DATA_W x PRE_W).
    function automatic int prod_w(input int data_w);
        return 2 * data_w + 2;
    endfunction

    // Largest value representable in a signed out_w-bit field.
    function automatic longint sat_hi(input int out_w);
        return (longint'(1) <<< (out_w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed out_w-bit field.
    function automatic longint sat_lo(input int out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

endpackage

// File: rtl/complex_mul_narrow.sv
// Combinational FULL_W -> OUT_W narrowing of one product component.
// COMPLEX_MUL_PIPE_ROUND_EN defined: round half up, then clamp, and flag clamping.
// COMPLEX_MUL_PIPE_ROUND_EN undefined: keep the top OUT_W bits (floor, wrap), no flag.
module complex_mul_narrow
    import complex_mul_pkg::*;
#(
    parameter int FULL_W = 17,
    parameter int OUT_W  = 17
) (
    input  logic signed [FULL_W-1:0] din,
    output logic signed [OUT_W-1:0]  dout,
    output logic                     sat
);

    localparam int SHIFT = FULL_W - OUT_W;

`ifdef COMPLEX_MUL_PIPE_ROUND_EN
    generate
        if (SHIFT == 0) begin : g_pass
            assign dout = din;
            assign sat  = 1'b0;
        end else begin : g_round
            // One guard bit above FULL_W absorbs the rounding bias without overflow.
            localparam logic signed [FULL_W:0] BIAS = (FULL_W + 1)'(1) << (SHIFT - 1);
            localparam logic signed [FULL_W:0] HI   = (FULL_W + 1)'(sat_hi(OUT_W));
            localparam logic signed [FULL_W:0] LO   = (FULL_W + 1)'(sat_lo(OUT_W));

            logic signed [FULL_W:0] rnd;
            logic signed [FULL_W:0] shf;

            // Round half up, arithmetic shift, then clamp to the output range.
            always_comb begin
                rnd  = (FULL_W + 1)'(din) + BIAS;
                shf  = rnd >>> SHIFT;
                dout = shf[OUT_W-1:0];
                sat  = 1'b0;
                if (shf > HI) begin
                    dout = HI[OUT_W-1:0];
                    sat  = 1'b1;
                end else if (shf < LO) begin
                    dout = LO[OUT_W-1:0];
                    sat  = 1'b1;
                end
            end
        end
    endgenerate
`else
    // Dropped LSBs are intentionally discarded by the floor narrowing.
    logic unused_lsb;
    assign unused_lsb = ^din;
    assign dout       = din[FULL_W-1:SHIFT];
    assign sat        = 1'b0;
`endif

endmodule

// File: rtl/complex_mul_pipe.sv
// Streaming 3-multiplier complex multiplier, P = A*B or A*conj(B), with a
// 4-stage valid/ready pipeline and a pass-through tag.
// Optional build macro COMPLEX_MUL_PIPE_ROUND_EN selects round/saturate narrowing;
// without it the output is floor-truncated and m_sat stays 0.
module complex_mul_pipe
    import complex_mul_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = full_w(DATA_W),
    parameter int TAG_W  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_a_re,
    input  logic signed [DATA_W-1:0] s_a_im,
    input  logic signed [DATA_W-1:0] s_b_re,
    input  logic signed [DATA_W-1:0] s_b_im,
    input  logic                     s_conj,
    input  logic [TAG_W-1:0]         s_tag,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [OUT_W-1:0]  m_re,
    output logic signed [OUT_W-1:0]  m_im,
    output logic [TAG_W-1:0]         m_tag,
    output logic                     m_sat
);

    localparam int FULL_W = full_w(DATA_W);
    localparam int BIM_W  = DATA_W + 1;
    localparam int PRE_W  = pre_w(DATA_W);
    localparam int PROD_W = prod_w(DATA_W);

    // b_im carries one extra bit so negating the most negative input is exact.
    typedef struct packed {
        logic signed [DATA_W-1:0] a_re;
        logic signed [DATA_W-1:0] a_im;
        logic signed [DATA_W-1:0] b_re;
        logic signed [BIM_W-1:0]  b_im;
        logic [TAG_W-1:0]         tag;
    } op_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] a_re;
        logic signed [DATA_W-1:0] a_im;
        logic signed [DATA_W-1:0] b_re;
        logic signed [PRE_W-1:0]  sa;
        logic signed [PRE_W-1:0]  sd;
        logic signed [PRE_W-1:0]  ss;
        logic [TAG_W-1:0]         tag;
    } pre_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] k1;
        logic signed [PROD_W-1:0] k2;
        logic signed [PROD_W-1:0] k3;
        logic [TAG_W-1:0]         tag;
    } prod_t;

    logic  v1, v2, v3, v4;
    logic  ready1, ready2, ready3, ready4;
    op_t   st1;
    pre_t  st2;
    prod_t st3;

    logic signed [FULL_W-1:0] re_full, im_full;
    logic signed [OUT_W-1:0]  re_nar, im_nar;
    logic                     re_sat, im_sat;

    // A stage may load when it is empty or its successor is loading this edge.
    assign ready4  = !v4 || m_ready;
    assign ready3  = !v3 || ready4;
    assign ready2  = !v2 || ready3;
    assign ready1  = !v1 || ready2;
    assign s_ready = ready1;
    assign m_valid = v4;

    // Both sums fit FULL_W exactly, so dropping the extra product bits is lossless.
    assign re_full = FULL_W'(st3.k1 - st3.k3);
    assign im_full = FULL_W'(st3.k1 + st3.k2);

    complex_mul_narrow #(.FULL_W(FULL_W), .OUT_W(OUT_W)) u_narrow_re (
        .din  (re_full),
        .dout (re_nar),
        .sat  (re_sat)
    );

    complex_mul_narrow #(.FULL_W(FULL_W), .OUT_W(OUT_W)) u_narrow_im (
        .din  (im_full),
        .dout (im_nar),
        .sat  (im_sat)
    );

    // S1: capture operands, folding the conjugate into b_im.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1  <= 1'b0;
            st1 <= '0;
        end else if (ready1) begin
            v1 <= s_valid;
            if (s_valid) begin
                st1.a_re <= s_a_re;
                st1.a_im <= s_a_im;
                st1.b_re <= s_b_re;
                st1.b_im <= s_conj ? -BIM_W'(s_b_im) : BIM_W'(s_b_im);
                st1.tag  <= s_tag;
            end
        end
    end

    // S2: the three pre-adds of the 3-multiplier decomposition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            st2 <= '0;
        end else if (ready2) begin
            v2 <= v1;
            if (v1) begin
                st2.a_re <= st1.a_re;
                st2.a_im <= st1.a_im;
                st2.b_re <= st1.b_re;
                st2.sa   <= PRE_W'(st1.a_re) + PRE_W'(st1.a_im);
                st2.sd   <= PRE_W'(st1.b_im) - PRE_W'(st1.b_re);
                st2.ss   <= PRE_W'(st1.b_re) + PRE_W'(st1.b_im);
                st2.tag  <= st1.tag;
            end
        end
    end

    // S3: three signed products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3  <= 1'b0;
            st3 <= '0;
        end else if (ready3) begin
            v3 <= v2;
            if (v2) begin
                st3.k1  <= PROD_W'(st2.b_re) * PROD_W'(st2.sa);
                st3.k2  <= PROD_W'(st2.a_re) * PROD_W'(st2.sd);
                st3.k3  <= PROD_W'(st2.a_im) * PROD_W'(st2.ss);
                st3.tag <= st2.tag;
            end
        end
    end

    // S4: post-adds and narrowing, registered straight onto the output port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v4    <= 1'b0;
            m_re  <= '0;
            m_im  <= '0;
            m_tag <= '0;
            m_sat <= 1'b0;
        end else if (ready4) begin
            v4 <= v3;
            if (v3) begin
                m_re  <= re_nar;
                m_im  <= im_nar;
                m_tag <= st3.tag;
                m_sat <= re_sat | im_sat;
            end
        end
    end

endmodule

// File: tb/tb_complex_mul_pipe.sv
// Self-checking bench for complex_mul_pipe: a full-width instance and an
// OUT_W=8 instance share all inputs; a scoreboard holds expected results.
module tb_complex_mul_pipe;

    localparam int DW = 8;
    localparam int TW = 4;

    typedef struct {
        int a_re;
        int a_im;
        int b_re;
        int b_im;
        bit conj;
        int tag;
    } stim_t;

    typedef struct {
        int             re;
        int             im;
        logic [7:0]     re8;
        logic [7:0]     im8;
        bit             sat8;
        logic [TW-1:0]  tag;
        int             cyc_in;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_conj = 1'b0;
    logic m_ready = 1'b1;
    logic signed [DW-1:0] s_a_re = '0;
    logic signed [DW-1:0] s_a_im = '0;
    logic signed [DW-1:0] s_b_re = '0;
    logic signed [DW-1:0] s_b_im = '0;
    logic [TW-1:0] s_tag = '0;

    logic s_ready, m_valid, m_sat;
    logic signed [16:0] m_re, m_im;
    logic [TW-1:0] m_tag;

    logic s8_ready, m8_valid, m8_sat;
    logic signed [7:0] m8_re, m8_im;
    logic [TW-1:0] m8_tag;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    stim_t cur;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    complex_mul_pipe #(.DATA_W(DW), .OUT_W(17), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_a_re(s_a_re), .s_a_im(s_a_im), .s_b_re(s_b_re), .s_b_im(s_b_im),
        .s_conj(s_conj), .s_tag(s_tag), .m_valid(m_valid), .m_ready(m_ready),
        .m_re(m_re), .m_im(m_im), .m_tag(m_tag), .m_sat(m_sat)
    );

    complex_mul_pipe #(.DATA_W(DW), .OUT_W(8), .TAG_W(TW)) dut8 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s8_ready),
        .s_a_re(s_a_re), .s_a_im(s_a_im), .s_b_re(s_b_re), .s_b_im(s_b_im),
        .s_conj(s_conj), .s_tag(s_tag), .m_valid(m8_valid), .m_ready(m_ready),
        .m_re(m8_re), .m_im(m8_im), .m_tag(m8_tag), .m_sat(m8_sat)
    );

    // Reference narrowing of a full 17-bit value to 8 bits: {sat, value}.
    function automatic logic [8:0] nar8(input int full);
        int r;
`ifdef COMPLEX_MUL_PIPE_ROUND_EN
        r = (full + 256) >>> 9;
        if (r > 127) return {1'b1, 8'h7f};
        if (r < -128) return {1'b1, 8'h80};
        return {1'b0, r[7:0]};
`else
        r = full >>> 9;
        return {1'b0, r[7:0]};
`endif
    endfunction

    function automatic exp_t model(input stim_t s, input int c);
        exp_t e;
        int bi;
        logic [8:0] n;
        bi = s.conj ? -s.b_im : s.b_im;
        e.re = s.a_re * s.b_re - s.a_im * bi;
        e.im = s.a_re * bi + s.a_im * s.b_re;
        n = nar8(e.re);
        e.sat8 = n[8];
        e.re8 = n[7:0];
        n = nar8(e.im);
        e.sat8 = e.sat8 | n[8];
        e.im8 = n[7:0];
        e.tag = s.tag[TW-1:0];
        e.cyc_in = c;
        return e;
    endfunction

    task automatic add_stim(input int ar, input int ai, input int br, input int bi,
                            input bit cj, input int tg);
        stim_t s;
        s.a_re = ar; s.a_im = ai; s.b_re = br; s.b_im = bi; s.conj = cj; s.tag = tg;
        stim_q.push_back(s);
    endtask

    task automatic drive_next();
        if (stim_q.size() > 0) begin
            cur = stim_q.pop_front();
            s_a_re = DW'(cur.a_re);
            s_a_im = DW'(cur.a_im);
            s_b_re = DW'(cur.b_re);
            s_b_im = DW'(cur.b_im);
            s_conj = cur.conj;
            s_tag = TW'(cur.tag);
            s_valid = 1'b1;
        end else begin
            s_valid = 1'b0;
        end
    endtask

    // Streams stim_q through the DUT, scoring every output against the model.
    task automatic run_stream(input bit rand_ready);
        int budget, tail, occ, acc, hs;
        bit prev_stall;
        logic signed [16:0] p_re, p_im;
        logic [TW-1:0] p_tag;
        logic p_sat;
        exp_t e;
        budget = 0; tail = 0; occ = 0; prev_stall = 1'b0;
        p_re = '0; p_im = '0; p_tag = '0; p_sat = 1'b0;
        @(posedge clk); #1;
        m_ready = rand_ready ? ($urandom_range(0, 9) < 4) : 1'b1;
        drive_next();
        while (budget < 600) begin
            @(negedge clk);
            budget++;
            n_checks++;
            if (s_ready !== ((occ < 4) || m_ready)) begin
                n_fail++;
                $display("FAIL s_ready: got %b want %b (held %0d, m_ready %b)",
                         s_ready, ((occ < 4) || m_ready), occ, m_ready);
            end
            if (prev_stall) begin
                n_checks++;
                if ({m_valid, m_re, m_im, m_tag, m_sat} !== {1'b1, p_re, p_im, p_tag, p_sat}) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%b re=%0d im=%0d tag=%0d sat=%b want v=1 re=%0d im=%0d tag=%0d sat=%b",
                             m_valid, m_re, m_im, m_tag, m_sat, p_re, p_im, p_tag, p_sat);
                end
            end
            hs = 0; acc = 0;
            if (m_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_output: got m_valid=1 tag=%0d re=%0d, want no output", m_tag, m_re);
                end else if (m_ready) begin
                    hs = 1;
                    e = exp_q.pop_front();
                    if ({m_re, m_im, m_tag} !== {17'(e.re), 17'(e.im), e.tag}) begin
                        n_fail++;
                        $display("FAIL result: got re=%0d im=%0d tag=%0d want re=%0d im=%0d tag=%0d",
                                 m_re, m_im, m_tag, e.re, e.im, e.tag);
                    end
                    n_checks++;
                    if ({m8_valid, m8_re, m8_im, m8_sat} !== {1'b1, e.re8, e.im8, e.sat8}) begin
                        n_fail++;
                        $display("FAIL narrow8: got v=%b re=%0d im=%0d sat=%b want v=1 re=%0d im=%0d sat=%b (full %0d,%0d)",
                                 m8_valid, m8_re, m8_im, m8_sat, $signed(e.re8), $signed(e.im8), e.sat8, e.re, e.im);
                    end
                    if (!rand_ready) begin
                        n_checks++;
                        if (cyc - e.cyc_in != 4) begin
                            n_fail++;
                            $display("FAIL latency: got %0d cycles want 4 (tag %0d)", cyc - e.cyc_in, e.tag);
                        end
                    end
                end
            end
            if (s_valid && s_ready) begin
                acc = 1;
                exp_q.push_back(model(cur, cyc));
            end
            occ = occ + acc - hs;
            prev_stall = m_valid && !m_ready;
            p_re = m_re; p_im = m_im; p_tag = m_tag; p_sat = m_sat;
            if (!s_valid && stim_q.size() == 0 && exp_q.size() == 0) tail++;
            if (tail >= 6) break;
            @(posedge clk); #1;
            if (acc == 1 || !s_valid) drive_next();
            m_ready = rand_ready ? ($urandom_range(0, 9) < 4) : 1'b1;
        end
        n_checks++;
        if (tail < 6) begin
            n_fail++;
            $display("FAIL stream_timeout: got %0d results outstanding, want 0", exp_q.size());
            exp_q.delete();
            stim_q.delete();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks += 6;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        if (m_re !== '0) begin n_fail++; $display("FAIL rst_m_re: got %0d want 0", m_re); end
        if (m_im !== '0) begin n_fail++; $display("FAIL rst_m_im: got %0d want 0", m_im); end
        if (m_tag !== '0) begin n_fail++; $display("FAIL rst_m_tag: got %0d want 0", m_tag); end
        if (m_sat !== 1'b0) begin n_fail++; $display("FAIL rst_m_sat: got %b want 0", m_sat); end
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks += 2;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_m_valid: got %b want 0", m_valid); end
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_basic();
        add_stim(3, 4, 5, -2, 1'b0, 1);
        add_stim(3, 4, 5, -2, 1'b1, 2);
        run_stream(1'b0);
    endtask

    task automatic test_corners();
        add_stim(-128, -128, -128, 0, 1'b1, 3);
        add_stim(-128, -128, 0, -128, 1'b1, 4);
        add_stim(-128, -128, -128, -128, 1'b1, 5);
        add_stim(127, 127, 127, -127, 1'b0, 6);
        add_stim(-3, -4, 5, -2, 1'b0, 7);
        add_stim(127, -128, -128, 127, 1'b1, 8);
        run_stream(1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++)
            add_stim(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     1'($urandom_range(0, 1)), i);
        run_stream(1'b0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++)
            add_stim(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     1'($urandom_range(0, 1)), i);
        run_stream(1'b1);
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        add_stim(3, 4, 5, -2, 1'b0, 9);
        add_stim(7, -5, 2, 9, 1'b1, 10);
        add_stim(-20, 11, 6, 3, 1'b0, 11);
        @(posedge clk); #1;
        drive_next();
        repeat (3) begin
            @(posedge clk); #1;
            drive_next();
        end
        @(posedge clk); #1;
        n_checks++;
        if (m_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", m_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_m_valid: got %b want 0", m_valid); end
        if (m_re !== '0) begin n_fail++; $display("FAIL mid_rst_m_re: got %0d want 0", m_re); end
        if (m_im !== '0) begin n_fail++; $display("FAIL mid_rst_m_im: got %0d want 0", m_im); end
        if (m_tag !== '0) begin n_fail++; $display("FAIL mid_rst_m_tag: got %0d want 0", m_tag); end
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_s_ready: got %b want 1", s_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        add_stim(-6, 2, 4, 8, 1'b1, 12);
        run_stream(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
